// File: rtl/adder_pipe.sv
// Pipelined add/sub/accumulate unit with valid/ready handshake and global stall.
// Optional build macro ADDER_SAT_EN: clamps ACC/SUB results and reports it on sat.
module adder_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH:0]   y,
  output logic                  sat
);

  localparam int YW = DATA_WIDTH + 1;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_ACC = 2'b10;
  localparam logic [1:0] OP_CLR = 2'b11;

  logic                advance;
  logic                accept;
  logic [YW-1:0]       acc_q;
  logic [YW-1:0]       acc_next;
  logic [YW-1:0]       res_p0;
  logic [LATENCY-1:0]  vld_p;
  logic [YW-1:0]       y_p [LATENCY];

`ifdef ADDER_SAT_EN
  logic                sat_p0;
  logic [LATENCY-1:0]  sat_p;

  function automatic logic [YW-1:0] sat_acc(input logic [YW:0] sum);
    return sum[YW] ? {YW{1'b1}} : sum[YW-1:0];
  endfunction

  function automatic logic [YW-1:0] sat_sub(input logic [DATA_WIDTH-1:0] x,
                                            input logic [DATA_WIDTH-1:0] z);
    return (x < z) ? '0 : ({1'b0, x} - {1'b0, z});
  endfunction
`endif

  // One global stall: everything moves only when the output slot is free or being taken.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;
  assign accept   = in_valid && advance;

  // Stage 0: compute the result and the next accumulator from the accepted beat.
  always_comb begin
    acc_next = acc_q;
    res_p0   = '0;
`ifdef ADDER_SAT_EN
    sat_p0   = 1'b0;
`endif
    case (op)
      OP_ADD: res_p0 = {1'b0, a} + {1'b0, b};
`ifdef ADDER_SAT_EN
      OP_SUB: begin
        res_p0 = sat_sub(a, b);
        sat_p0 = (a < b);
      end
      OP_ACC: begin
        acc_next = sat_acc({1'b0, acc_q} + {2'b00, a});
        sat_p0   = ({1'b0, acc_q} + {2'b00, a}) > {1'b0, {YW{1'b1}}};
        res_p0   = acc_next;
      end
`else
      OP_SUB: res_p0 = {1'b0, a} - {1'b0, b};
      OP_ACC: begin
        acc_next = acc_q + {1'b0, a};
        res_p0   = acc_next;
      end
`endif
      OP_CLR: begin
        acc_next = '0;
        res_p0   = '0;
      end
      default: res_p0 = '0;
    endcase
  end

  // Stages 1..LATENCY: the accumulator commits at accept, results shift under the global stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      vld_p <= '0;
      for (int i = 0; i < LATENCY; i++) y_p[i] <= '0;
`ifdef ADDER_SAT_EN
      sat_p <= '0;
`endif
    end else begin
      if (accept) acc_q <= acc_next;
      if (advance) begin
        vld_p[0] <= accept;
        y_p[0]   <= res_p0;
`ifdef ADDER_SAT_EN
        sat_p[0] <= sat_p0;
`endif
        for (int i = 1; i < LATENCY; i++) begin
          vld_p[i] <= vld_p[i-1];
          y_p[i]   <= y_p[i-1];
`ifdef ADDER_SAT_EN
          sat_p[i] <= sat_p[i-1];
`endif
        end
      end
    end
  end

  assign out_valid = vld_p[LATENCY-1];
  assign y         = y_p[LATENCY-1];
`ifdef ADDER_SAT_EN
  assign sat       = sat_p[LATENCY-1];
`else
  assign sat       = 1'b0;
`endif

endmodule
